// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state type and default frame sync word.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4C4F4144;

endpackage

// File: rtl/boot_loader_byte_assembler.sv
// Assembles little-endian 32-bit words from an accepted byte stream; doubles as the
// 4-byte sliding window used for frame sync.
module byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        handshake,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    // word is the window value including the byte being accepted this cycle, so the
    // consumer can act on the same edge that accepts the 4th byte.
    assign word      = {in_data, shreg[31:8]};
    assign word_done = handshake && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (handshake)
                shreg <= word;
            if (clear)
                cnt <= '0;
            else if (handshake)
                cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Receives a framed program image (MAGIC, LEN, data, CSUM) and writes it into cpu
// memory, releasing the cpu from reset only after the checksum verifies.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          BASE_ADDR  = 0,
    parameter logic [31:0] MAGIC      = DEFAULT_MAGIC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [32:0]           DEPTH = 33'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   ONE   = (ADDR_WIDTH+1)'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] len;
    logic [ADDR_WIDTH:0] idx;
    logic [31:0]         sum;
    logic [31:0]         word;
    logic                word_done;
    logic                handshake;
    logic                clear;

    assign in_ready   = (state != ST_RUN) && (state != ST_ERROR);
    assign handshake  = in_valid && in_ready;
    assign clear      = (state == ST_SYNC) && handshake && (word == MAGIC);
    assign cpu_reset  = (state == ST_RUN);
    assign load_done  = (state == ST_RUN);
    assign load_error = (state == ST_ERROR);
    assign word_count = idx;

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .handshake (handshake),
        .clear     (clear),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SYNC;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                ST_SYNC: begin
                    if (clear)
                        state <= ST_LEN;
                end
                ST_LEN: begin
                    if (word_done) begin
                        if (word == '0)
                            state <= ST_CSUM;
                        else if ({1'b0, word} > DEPTH)
                            state <= ST_ERROR;
                        else begin
                            len   <= word[ADDR_WIDTH:0];
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + idx[ADDR_WIDTH-1:0];
                        mem_wdata <= word;
                        idx       <= idx + ONE;
                        sum       <= sum + word;
                        if (idx + ONE == len)
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (word_done)
                        state <= (word == sum) ? ST_RUN : ST_ERROR;
                end
                default: ;
            endcase
        end
    end

endmodule
